aes_cipher_iter: RTL
====================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter: Nr, 10, number of AES rounds (10/12/14 for AES-128/192/256).
REQ-002 Parameter: Nk, 4, key length in 32-bit words; carried for key-schedule consistency only, no logic depends on it.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to encrypt; sampled only in IDLE.
REQ-006 Port: state  input  128  plaintext block, FIPS-197 byte order (byte 0 at [127:120], column-major).
REQ-007 Port: w  input  128*(Nr+1)  expanded key schedule; round key r at w[r*128 +: 128].
REQ-008 Port: busy  output  1  high while an encryption is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when Encrypted_Msg becomes valid.
REQ-010 Port: Encrypted_Msg  output  128  ciphertext, held stable until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, ROUND, FINAL; encoding is free.
REQ-012 In IDLE, start=1 SHALL register state XOR w[0+:128] into the internal state register, set the round counter to 1, assert busy and go to ROUND.
REQ-013 Plaintext and w SHALL be sampled only in the accept cycle for the plaintext and each cycle for the current round key; w SHALL be held stable by the producer while busy=1.
REQ-014 Each ROUND cycle SHALL apply SubBytes, ShiftRows, MixColumns, then AddRoundKey with w[round*128+:128], and increment the round counter.
REQ-015 When the counter reaches Nr-1 in ROUND, the next state SHALL be FINAL.
REQ-016 FINAL SHALL apply SubBytes, ShiftRows, AddRoundKey with w[Nr*128+:128] (no MixColumns), load Encrypted_Msg, pulse done, clear busy and return to IDLE.
REQ-017 Latency: done SHALL assert exactly Nr+1 cycles after the start-accept edge (11 for Nr=10); throughput one block per Nr+1 cycles.
REQ-018 start while busy=1 SHALL be ignored with no effect on the current operation.
REQ-019 start asserted in the cycle done is high SHALL be accepted, because the FSM is in IDLE that cycle; Encrypted_Msg SHALL keep the previous result until the new FINAL.
REQ-020 Round counter width SHALL be $clog2(Nr+1) bits and SHALL never exceed Nr.
REQ-021 GF(2^8) arithmetic SHALL use polynomial 0x11B; MixColumns matrix {02,03,01,01} circulant.

Reset
REQ-022 reset=1 SHALL force IDLE, busy=0, done=0, Encrypted_Msg=0, internal state=0 and counter=0 at the next edge.
REQ-023 reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted block.
REQ-024 reset SHALL take priority over start in the same cycle.

Structure
REQ-025 A shared package SHALL hold the S-box table, the xtime function and the round-count constants for AES-128/192/256.
REQ-026 One combinational sub-module aes_round (inputs: state, round key, final flag) SHALL implement one round; the top SHALL instantiate it once and iterate.
REQ-027 Only the state register, counter, FSM and output register SHALL be sequential.

Verification
REQ-028 FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, w expanded from key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done 11 cycles later, Encrypted_Msg=3925841d02dc09fbdc118597196a0b32.
REQ-029 FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> Encrypted_Msg=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 start held high for 20 cycles with the App. B vector -> blocks accepted at cycles 0 and 11, done at cycles 11 and 22, busy low only in the accept cycle's preceding IDLE.
REQ-031 start pulsed again at cycle 5 of an operation with different plaintext -> ignored; result equals the first block's ciphertext.
REQ-032 reset at cycle 6 of an operation -> busy=0, done=0, Encrypted_Msg=0 the next cycle; no done for 20 cycles; a new App. C.1 start then yields 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Round-trip: Encrypted_Msg fed with the same w to the team's combinational decryption block -> original plaintext for 100 random blocks and keys.

Source files
------------

// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES constants and byte-level helpers: the S-box, xtime over GF(2^8)/0x11B,
// and the round counts for each key size.
package aes_cipher_iter_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by {02} modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; MixColumns is bypassed when final_round is set.
module aes_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] result
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte gi sits at [127-8*gi -: 8]; row = gi % 4, column = gi / 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb[gi] = sub_byte(state[127-8*gi -: 8]);
    assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi];
    assign a1 = sr[4*gi+1];
    assign a2 = sr[4*gi+2];
    assign a3 = sr[4*gi+3];
    assign mc[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_add_key
    assign result[127-8*gi -: 8] = (final_round ? sr[gi] : mc[gi]) ^ round_key[127-8*gi -: 8];
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock through a single shared aes_round,
// Nr+1 cycles from accept to the done pulse.
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int Nr = NR_AES128,
  parameter int Nk = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [127:0]          state,
  input  logic [128*(Nr+1)-1:0] w,
  output logic                  busy,
  output logic                  done,
  output logic [127:0]          Encrypted_Msg
);

  localparam int CW = $clog2(Nr + 1);

  // Nk only guards that the key schedule matches the round count.
  if ((Nr != NR_AES128 && Nr != NR_AES192 && Nr != NR_AES256) || Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_cipher_iter: Nr/Nk combination is not a valid AES variant");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t          fsm_reg;
  logic [127:0]  state_reg;
  logic [CW-1:0] round_reg;
  logic [127:0]  round_key;
  logic [127:0]  round_result;

  assign round_key = w[int'(round_reg)*128 +: 128];

  aes_round u_round (
    .state       (state_reg),
    .round_key   (round_key),
    .final_round (fsm_reg == FINAL),
    .result      (round_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_reg     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      Encrypted_Msg <= '0;
    end else begin
      done <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= state ^ w[127:0];
            round_reg <= CW'(1);
            busy      <= 1'b1;
            fsm_reg   <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_result;
          round_reg <= round_reg + CW'(1);
          if (round_reg == CW'(Nr - 1)) fsm_reg <= FINAL;
        end
        FINAL: begin
          // The counter now sits at Nr and stays there until the next accept.
          Encrypted_Msg <= round_result;
          done          <= 1'b1;
          busy          <= 1'b0;
          fsm_reg       <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule
